// File: rtl/clock_prog_gen.sv
// ---------------------------------------------------------------------------
// clock_prog_gen -- programmable clock divider with STOP/START run control.
//
// Produces a registered divided clock (clk_out) with a programmable period
// and high time, and a one-cycle tick on the last cycle of every period.
// Period/high values are sampled on entering START and re-sampled at every
// period boundary, so reprogramming never disturbs a period in progress.
//
// Optional feature (macro CLOCK_PROG_CYCLE_CNT_EN): adds a 16-bit `cycles`
// output counting completed output periods.
//
// Ports:
//   clk       in   system clock, rising edge
//   resetn    in   asynchronous reset, ACTIVE-HIGH despite the name
//   start     in   request to enter START (level sampled)
//   stop      in   request to enter STOP (level sampled, wins over start)
//   period    in   [CNT_W] output period in clk cycles (0/1 treated as 2)
//   high_cnt  in   [CNT_W] clk cycles per period that clk_out is high
//   clk_out   out  registered divided clock, high phase first
//   tick      out  pulse on the last cycle of each output period
//   state     out  0 = STOP, 1 = START
//   cycles    out  [16] completed periods (only with CLOCK_PROG_CYCLE_CNT_EN)
// ---------------------------------------------------------------------------
module clock_prog_gen #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] high_cnt,
    output logic             clk_out,
    output logic             tick,
`ifdef CLOCK_PROG_CYCLE_CNT_EN
    output logic [15:0]      cycles,
`endif
    output logic             state
);

    typedef enum logic {
        StStop  = 1'b0,
        StStart = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntTwo = CNT_W'(2);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    // Sanitised view of the live inputs: P = max(period, 2), H = min(high_cnt, P).
    logic [CNT_W-1:0] in_per;
    logic [CNT_W-1:0] in_high;

    always_comb begin
        in_per  = (period < CntTwo) ? CntTwo : period;
        in_high = (high_cnt > in_per) ? in_per : high_cnt;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        per_d     = per_q;
        high_d    = high_q;
        clk_out_d = 1'b0;
        tick_d    = 1'b0;

        case (state_q)
            StStop: begin
                cnt_d = '0;
                if (start && !stop) begin
                    state_d   = StStart;
                    per_d     = in_per;
                    high_d    = in_high;
                    clk_out_d = (in_high != '0);
                end
            end
            StStart: begin
                if (stop) begin
                    // Abort immediately; the current period is not completed.
                    state_d = StStop;
                    cnt_d   = '0;
                end else if (cnt_q == per_q - CntOne) begin
                    // Period boundary: pick up new settings for the next period.
                    // Tick cannot fire here since the new P is always >= 2.
                    cnt_d     = '0;
                    per_d     = in_per;
                    high_d    = in_high;
                    clk_out_d = (in_high != '0);
                end else begin
                    cnt_d     = cnt_q + CntOne;
                    clk_out_d = (cnt_d < high_q);
                    tick_d    = (cnt_d == per_q - CntOne);
                end
            end
            default: begin
                state_d = StStop;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q   <= StStop;
            cnt_q     <= '0;
            per_q     <= '0;
            high_q    <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            high_q    <= high_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign state   = state_q;

`ifdef CLOCK_PROG_CYCLE_CNT_EN
    logic [15:0] cycles_q;

    // Counts the registered tick, so a period is counted on the edge after it ends.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            cycles_q <= '0;
        end else if (state_q == StStop && state_d == StStart) begin
            cycles_q <= '0;
        end else if (state_q == StStart && tick_q) begin
            cycles_q <= cycles_q + 16'd1;
        end
    end

    assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_clock_prog_gen.sv
module tb_clock_prog_gen;

    logic       clk;
    logic       resetn;
    logic       start;
    logic       stop;
    logic [7:0] period;
    logic [7:0] high_cnt;
    logic       clk_out;
    logic       tick;
    logic       state;
`ifdef CLOCK_PROG_CYCLE_CNT_EN
    logic [15:0] cycles;
`endif

    int checks   = 0;
    int failures = 0;

    clock_prog_gen #(.CNT_W(8)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .stop     (stop),
        .period   (period),
        .high_cnt (high_cnt),
        .clk_out  (clk_out),
        .tick     (tick),
`ifdef CLOCK_PROG_CYCLE_CNT_EN
        .cycles   (cycles),
`endif
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: position within the current output period.
    bit m_run;
    int m_ph;
    int m_p;
    int m_h;
    bit m_clk;
    bit m_tick;
    int m_cyc;

    task automatic m_reset();
        m_run  = 0;
        m_ph   = 0;
        m_p    = 0;
        m_h    = 0;
        m_clk  = 0;
        m_tick = 0;
        m_cyc  = 0;
    endtask

    task automatic m_latch();
        m_p = (int'(period) < 2) ? 2 : int'(period);
        m_h = (int'(high_cnt) > m_p) ? m_p : int'(high_cnt);
    endtask

    // One rising edge of the reference, using the inputs currently applied.
    task automatic m_edge();
        bit was_run;
        bit was_tick;
        was_run  = m_run;
        was_tick = m_tick;
        if (stop) begin
            m_run = 0;
        end else if (!m_run && start) begin
            m_run = 1;
            m_ph  = 0;
            m_cyc = 0;
            m_latch();
        end else if (m_run) begin
            m_ph++;
            if (m_ph == m_p) begin
                m_ph = 0;
                m_latch();
            end
        end
        m_clk  = m_run && (m_ph < m_h);
        m_tick = m_run && (m_ph == m_p - 1);
        if (was_run && was_tick) m_cyc = (m_cyc + 1) % 65536;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clk edge in DUT and model, then compare on the falling edge.
    task automatic step();
        @(posedge clk);
        m_edge();
        @(negedge clk);
        chk("state", 32'(state), 32'(m_run));
        chk("clk_out", 32'(clk_out), 32'(m_clk));
        chk("tick", 32'(tick), 32'(m_tick));
`ifdef CLOCK_PROG_CYCLE_CNT_EN
        chk("cycles", 32'(cycles), 32'(m_cyc));
`endif
    endtask

    initial begin
        bit pat4 [4];
        bit rp_clk [8];
        bit rp_tick [8];
        pat4    = '{1, 1, 0, 0};
        rp_clk  = '{0, 0, 1, 0, 0, 0, 0, 0};
        rp_tick = '{0, 1, 0, 0, 0, 0, 0, 1};

        resetn   = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        period   = 8'd0;
        high_cnt = 8'd0;
        m_reset();

        // Reset, then idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        resetn = 1'b0;
        repeat (10) step();

        // Basic divide 4/2.
        period   = 8'd4;
        high_cnt = 8'd2;
        start    = 1'b1;
        step();
        chk("basic_enter_start", 32'(state), 32'd1);
        chk("basic_first_high", 32'(clk_out), 32'd1);
        start = 1'b0;
        for (int i = 1; i < 12; i++) begin
            step();
            chk("basic_pat", 32'(clk_out), 32'(pat4[i % 4]));
            chk("basic_tick", 32'(tick), 32'((i % 4) == 3));
        end

        // Reprogram during the 2nd cycle of a period.
        step();
        step();
        period   = 8'd6;
        high_cnt = 8'd1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("reprog_clk", 32'(clk_out), 32'(rp_clk[i]));
            chk("reprog_tick", 32'(tick), 32'(rp_tick[i]));
        end

        // Start/stop race.
        stop = 1'b1;
        step();
        start = 1'b1;
        step();
        chk("race_stays_stop", 32'(state), 32'd0);
        start    = 1'b0;
        stop     = 1'b0;
        period   = 8'd5;
        high_cnt = 8'd3;
        start    = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        stop = 1'b1;
        step();
        chk("stop_state", 32'(state), 32'd0);
        chk("stop_clk_out", 32'(clk_out), 32'd0);
        chk("stop_tick", 32'(tick), 32'd0);
        stop = 1'b0;

        // period=1 behaves as 2.
        period   = 8'd1;
        high_cnt = 8'd1;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i < 6; i++) begin
            step();
            chk("p1_toggle", 32'(clk_out), 32'((i % 2) == 0));
        end

        // high_cnt=0: clk_out stays low, tick still every 2 cycles.
        stop = 1'b1;
        step();
        stop     = 1'b0;
        high_cnt = 8'd0;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i < 6; i++) begin
            step();
            chk("h0_low", 32'(clk_out), 32'd0);
            chk("h0_tick", 32'(tick), 32'((i % 2) == 1));
        end

        // high_cnt >= P: clk_out stays high.
        stop = 1'b1;
        step();
        stop     = 1'b0;
        period   = 8'd3;
        high_cnt = 8'd9;
        start    = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i < 6; i++) begin
            step();
            chk("hbig_high", 32'(clk_out), 32'd1);
        end

        // Randomised run/reprogram against the model.
        for (int i = 0; i < 400; i++) begin
            start = ($urandom % 6) == 0;
            stop  = ($urandom % 20) == 0;
            if (($urandom % 7) == 0) period = 8'($urandom_range(0, 9));
            if (($urandom % 7) == 0) high_cnt = 8'($urandom_range(0, 11));
            step();
        end

        // Three full periods of 4, then asynchronous reset between edges.
        start    = 1'b0;
        stop     = 1'b1;
        step();
        stop     = 1'b0;
        period   = 8'd4;
        high_cnt = 8'd2;
        start    = 1'b1;
        step();
        start = 1'b0;
        repeat (12) step();
`ifdef CLOCK_PROG_CYCLE_CNT_EN
        chk("cycles_three", 32'(cycles), 32'd3);
`endif
        @(posedge clk);
        #2 resetn = 1'b1;
        #1;
        m_reset();
        chk("async_state", 32'(state), 32'd0);
        chk("async_clk_out", 32'(clk_out), 32'd0);
        chk("async_tick", 32'(tick), 32'd0);
`ifdef CLOCK_PROG_CYCLE_CNT_EN
        chk("async_cycles", 32'(cycles), 32'd0);
`endif
        @(negedge clk);
        resetn = 1'b0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_prog_gen.md
Name: clock_prog_gen

Overview:
- Programmable clock generator/divider with run control, one clock domain.
- Produces a divided output clock `clk_out` with programmable period and high time, plus an end-of-period `tick` pulse.
- Exposes a two-state run FSM (STOP/START) on `state` for enum coverage in verification.
- Used as the test/stimulus clock source in simulation and as a synthesizable divider.

Parameters:
- CNT_W, 8, width of the period/high-time inputs and the internal counter.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- resetn  input  1  reset. Asynchronous, active-high: 1 = reset asserted, despite the suffix.
- start  input  1  level-sampled request to enter START.
- stop  input  1  level-sampled request to enter STOP.
- period  input  CNT_W  output period in clk cycles.
- high_cnt  input  CNT_W  clk cycles per period that clk_out is high.
- clk_out  output  1  registered programmable clock.
- tick  output  1  one-cycle pulse on the last cycle of each output period.
- state  output  1  FSM state: 0 = STOP, 1 = START.

Behaviour:
- Reset (resetn=1, asynchronous):
  - state=STOP, clk_out=0, tick=0.
  - Internal counter=0; latched period and high values = 0.
- STOP:
  - clk_out=0, tick=0, counter held at 0.
- STOP -> START:
  - Taken at the edge where start=1 and stop=0.
  - At that edge: P = max(period, 2), H = min(high_cnt, P).
  - counter<=0, clk_out<=(H>0), tick<=(P-1==0)=0.
- START, each edge:
  - next = (counter==P-1) ? 0 : counter+1.
  - counter<=next; clk_out<=(next<H); tick<=(next==P-1).
- Period boundary:
  - When counter wraps to 0, re-latch P and H from the current inputs.
  - Input changes therefore take effect only at a period boundary, never mid-period.
- START -> STOP:
  - Taken at any edge with stop=1.
  - At that edge: counter<=0, clk_out<=0, tick<=0. No completion of the current period.
- Simultaneous start and stop: stop wins, in either state.
- start while already in START: ignored.
- Degenerate values:
  - period 0 or 1 is treated as 2.
  - high_cnt=0: clk_out stays 0, but tick still pulses.
  - high_cnt>=P: clk_out stays 1.
- Latency: clk_out first rises at the same edge that moves state to START, i.e. one clk after start is presented.
- Duty: clk_out is high for exactly H of every P cycles, and the high phase comes first.
- Reset asserted mid-operation: immediate return to the reset values above; no glitch-filtering.
- All outputs come directly from flops; there are no combinational outputs.

Optional Feature:
- Macro: CLOCK_PROG_CYCLE_CNT_EN.
- When defined:
  - Adds output port `cycles`, 16 bits: count of completed output periods.
  - Increments on each edge where tick=1 and state=START.
  - Wraps 0xFFFF->0.
  - Cleared by reset and on the STOP->START transition; holds its value in STOP.
- When not defined: no `cycles` port and no counter logic; all other behaviour identical.

Test Plan:
- Reset then idle: resetn=1 for 3 cycles, release, start=stop=0 for 10 cycles -> state=0, clk_out=0, tick=0 throughout.
- Basic divide: period=4, high_cnt=2, start pulse -> state=1 next edge; clk_out pattern 1,1,0,0 repeating; tick high on every 4th cycle, aligned with the last 0.
- Reprogram mid-run: change period to 6, high_cnt=1 during the 2nd cycle of a period -> current period finishes as 4/2, then the pattern becomes 1,0,0,0,0,0.
- Start/stop race: assert start=stop=1 while in STOP -> state stays 0. Then run with period=5, high_cnt=3, assert stop at count 2 -> next edge state=0, clk_out=0, tick=0.
- Boundaries:
  - period=1, high_cnt=1 -> behaves as P=2, clk_out toggles 1,0.
  - high_cnt=0 -> clk_out constant 0, tick still every 2 cycles.
  - period=3, high_cnt=9 -> clk_out constant 1.
- Async reset mid-run plus option: with CLOCK_PROG_CYCLE_CNT_EN, run period=4 for 3 full periods -> cycles=3. Assert resetn between edges -> state, clk_out, cycles go to 0 immediately without waiting for clk.
